// File: rtl/mips8_pkg.sv
// -----------------------------------------------------------------------------
// mips8_pkg
// Shared types and constants for the 8-bit MIPS core. The instruction ROM,
// the fetch stage and the decode stage all use these definitions.
//   INSTR_W / ADDR_W   : instruction and address widths
//   instr_t / addr_t   : instruction word and byte-free word address
//   fetch_state_e      : fetch FSM states (RUN, HALT)
//   ifid_ctrl_e        : per-edge command to the IF/ID pipeline register
//   HALT_WORD_DEFAULT  : default encoding of the halt instruction
// -----------------------------------------------------------------------------
package mips8_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 8;

    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [ADDR_W-1:0]  addr_t;

    localparam instr_t HALT_WORD_DEFAULT = 16'h0000;

    typedef enum logic {
        RUN,
        HALT
    } fetch_state_e;

    // HOLD keeps everything, LOAD captures a fetched word, SQUASH inserts a
    // redirect bubble, DROP only clears the valid flag (used while halted).
    typedef enum logic [1:0] {
        IFID_HOLD,
        IFID_LOAD,
        IFID_SQUASH,
        IFID_DROP
    } ifid_ctrl_e;

endpackage

// File: rtl/instruction_fetch_ifid.sv
// -----------------------------------------------------------------------------
// ifid_register
// IF/ID pipeline register: holds the instruction handed to decode, the address
// it came from and its valid flag.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   ctrl         : HOLD / LOAD / SQUASH / DROP command for this edge
//   next_instr   : word to capture on LOAD
//   next_pc      : address to capture on LOAD or SQUASH
//   instr        : registered instruction
//   instr_pc     : registered instruction address
//   instr_valid  : instr is a real, non-squashed instruction
// -----------------------------------------------------------------------------
module ifid_register
    import mips8_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  ifid_ctrl_e         ctrl,
    input  logic [INSTR_W-1:0] next_instr,
    input  logic [ADDR_W-1:0]  next_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid
);

    // NOTE: clocked state uses non-blocking (<=) assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (ctrl)
                IFID_LOAD: begin
                    instr       <= next_instr;
                    instr_pc    <= next_pc;
                    instr_valid <= 1'b1;
                end
                IFID_SQUASH: begin
                    instr       <= '0;
                    instr_pc    <= next_pc;
                    instr_valid <= 1'b0;
                end
                IFID_DROP: begin
                    instr_valid <= 1'b0;
                end
                default: begin
                    // hold
                end
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage of the 8-bit MIPS core. Owns the PC, drives the combinational
// instruction ROM address and registers the returned word into IF/ID.
// Handles sequential fetch, stall, and branch/jump redirect with a one-cycle
// squash bubble. Priority per edge: reset > redirect > halt > stall > normal.
//
// Build option: define HALT_DETECT_EN to freeze fetch when HALT_WORD is
// fetched (state HALT, halted=1) until reset or redirect. Without it, there is
// no halt behaviour and halted is tied low.
//
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   stall            : hold PC and IF/ID contents
//   redirect_valid   : branch/jump taken this cycle
//   redirect_target  : new PC on redirect
//   imem_address     : ROM address, combinational copy of pc
//   imem_data        : ROM data, same cycle
//   instr            : registered instruction to decode
//   instr_pc         : address instr was fetched from
//   instr_valid      : instr holds a real, non-squashed instruction
//   halted           : fetch frozen on halt word
//   fetch_count      : instructions delivered with instr_valid=1 (wraps)
// -----------------------------------------------------------------------------
module instruction_fetch
    import mips8_pkg::*;
#(
    parameter addr_t  RESET_PC  = 8'h00,
    parameter instr_t HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic [ADDR_W-1:0]  imem_address,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    fetch_state_e state_q, state_d;
    addr_t        pc_q, pc_d;
    logic [15:0]  count_q, count_d;
    ifid_ctrl_e   ifid_ctrl;
    addr_t        ifid_pc;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        count_d   = count_q;
        ifid_ctrl = IFID_HOLD;
        ifid_pc   = pc_q;

        if (redirect_valid) begin
            pc_d      = redirect_target;
            state_d   = RUN;
            ifid_ctrl = IFID_SQUASH;
            ifid_pc   = redirect_target;
        end else if (state_q == HALT) begin
            // Stall is ignored while halted; valid drops every edge.
            ifid_ctrl = IFID_DROP;
        end else if (!stall) begin
            ifid_ctrl = IFID_LOAD;
            count_d   = count_q + 16'd1;
            pc_d      = pc_q + 8'd1;   // wraps FF -> 00
`ifdef HALT_DETECT_EN
            // The halt word is still delivered to decode, but PC parks on it.
            if (imem_data == HALT_WORD) begin
                pc_d    = pc_q;
                state_d = HALT;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    ifid_register u_ifid (
        .clk         (clk),
        .reset       (reset),
        .ctrl        (ifid_ctrl),
        .next_instr  (imem_data),
        .next_pc     (ifid_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid)
    );

    assign imem_address = pc_q;
    assign fetch_count  = count_q;

`ifdef HALT_DETECT_EN
    assign halted = (state_q == HALT);
`else
    // Without halt detection the HALT state is unreachable.
    logic unused_halt_word;
    assign unused_halt_word = ^HALT_WORD;
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed bench for instruction_fetch with a combinational ROM model.
// Expected values are hand-computed; HALT_DETECT_EN selects the halt-build
// expectations at the end of the sequence.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [7:0]  redirect_target;
    logic [7:0]  imem_address;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] rom [256];

    int checks;
    int errors;

    instruction_fetch #(
        .RESET_PC  (8'h00),
        .HALT_WORD (16'h0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_address    (imem_address),
        .imem_data       (imem_data),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    assign imem_data = rom[imem_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_if(input string tag, input logic valid,
                             input logic [15:0] exp_instr, input logic [7:0] exp_ipc,
                             input logic [7:0] exp_addr, input logic [15:0] exp_count,
                             input logic exp_halted);
        check({tag, ".valid"},  32'(instr_valid),  32'(valid));
        check({tag, ".instr"},  32'(instr),        32'(exp_instr));
        check({tag, ".ipc"},    32'(instr_pc),     32'(exp_ipc));
        check({tag, ".addr"},   32'(imem_address), 32'(exp_addr));
        check({tag, ".count"},  32'(fetch_count),  32'(exp_count));
        check({tag, ".halted"}, 32'(halted),       32'(exp_halted));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h8000 | 16'(i);
        rom[8'h00] = 16'h4800;
        rom[8'h01] = 16'h4A0C;
        rom[8'h02] = 16'h4C06;
        rom[8'h06] = 16'h0E80;
        rom[8'h09] = 16'h0000;

        reset           = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 8'h00;

        // Reset state, held over two edges.
        step();
        expect_if("rst0", 1'b0, 16'h0000, 8'h00, 8'h00, 16'd0, 1'b0);
        step();
        expect_if("rst1", 1'b0, 16'h0000, 8'h00, 8'h00, 16'd0, 1'b0);
        reset = 1'b0;

        // Sequential fetch.
        step(); expect_if("seq0", 1'b1, 16'h4800, 8'h00, 8'h01, 16'd1, 1'b0);
        step(); expect_if("seq1", 1'b1, 16'h4A0C, 8'h01, 8'h02, 16'd2, 1'b0);
        step(); expect_if("seq2", 1'b1, 16'h4C06, 8'h02, 8'h03, 16'd3, 1'b0);
        step(); expect_if("seq3", 1'b1, 16'h8003, 8'h03, 8'h04, 16'd4, 1'b0);

        // Redirect to 06 while pc=04: one bubble, then fetch from target.
        redirect_valid = 1'b1; redirect_target = 8'h06;
        step(); expect_if("rdr6", 1'b0, 16'h0000, 8'h06, 8'h06, 16'd4, 1'b0);
        redirect_valid = 1'b0;
        step(); expect_if("tgt6", 1'b1, 16'h0E80, 8'h06, 8'h07, 16'd5, 1'b0);

        // Fresh reset, then stall for two cycles after fetching 01.
        reset = 1'b1;
        step(); expect_if("rst2", 1'b0, 16'h0000, 8'h00, 8'h00, 16'd0, 1'b0);
        reset = 1'b0;
        step(); expect_if("b0",   1'b1, 16'h4800, 8'h00, 8'h01, 16'd1, 1'b0);
        step(); expect_if("b1",   1'b1, 16'h4A0C, 8'h01, 8'h02, 16'd2, 1'b0);
        stall = 1'b1;
        step(); expect_if("stl0", 1'b1, 16'h4A0C, 8'h01, 8'h02, 16'd2, 1'b0);
        step(); expect_if("stl1", 1'b1, 16'h4A0C, 8'h01, 8'h02, 16'd2, 1'b0);
        stall = 1'b0;
        step(); expect_if("res",  1'b1, 16'h4C06, 8'h02, 8'h03, 16'd3, 1'b0);

        // Redirect while stalled: redirect wins.
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h02;
        step(); expect_if("rdst", 1'b0, 16'h0000, 8'h02, 8'h02, 16'd3, 1'b0);
        stall = 1'b0; redirect_valid = 1'b0;
        step(); expect_if("tgt2", 1'b1, 16'h4C06, 8'h02, 8'h03, 16'd4, 1'b0);

        // Back-to-back redirects: last target wins, bubble each cycle.
        redirect_valid = 1'b1; redirect_target = 8'h10;
        step(); expect_if("bb0", 1'b0, 16'h0000, 8'h10, 8'h10, 16'd4, 1'b0);
        redirect_target = 8'h20;
        step(); expect_if("bb1", 1'b0, 16'h0000, 8'h20, 8'h20, 16'd4, 1'b0);
        redirect_valid = 1'b0;
        step(); expect_if("bb2", 1'b1, 16'h8020, 8'h20, 8'h21, 16'd5, 1'b0);

        // PC wrap at FF.
        redirect_valid = 1'b1; redirect_target = 8'hFF;
        step(); expect_if("wr0", 1'b0, 16'h0000, 8'hFF, 8'hFF, 16'd5, 1'b0);
        redirect_valid = 1'b0;
        step(); expect_if("wr1", 1'b1, 16'h80FF, 8'hFF, 8'h00, 16'd6, 1'b0);

        // Run into the halt word at 09.
        redirect_valid = 1'b1; redirect_target = 8'h08;
        step(); expect_if("h0", 1'b0, 16'h0000, 8'h08, 8'h08, 16'd6, 1'b0);
        redirect_valid = 1'b0;
        step(); expect_if("h1", 1'b1, 16'h8008, 8'h08, 8'h09, 16'd7, 1'b0);
`ifdef HALT_DETECT_EN
        step(); expect_if("h2", 1'b1, 16'h0000, 8'h09, 8'h09, 16'd8, 1'b1);
        step(); expect_if("h3", 1'b0, 16'h0000, 8'h09, 8'h09, 16'd8, 1'b1);
        stall = 1'b1;
        step(); expect_if("h4", 1'b0, 16'h0000, 8'h09, 8'h09, 16'd8, 1'b1);
        stall = 1'b0; redirect_valid = 1'b1; redirect_target = 8'h00;
        step(); expect_if("h5", 1'b0, 16'h0000, 8'h00, 8'h00, 16'd8, 1'b0);
        redirect_valid = 1'b0;
        step(); expect_if("h6", 1'b1, 16'h4800, 8'h00, 8'h01, 16'd9, 1'b0);
`else
        step(); expect_if("h2", 1'b1, 16'h0000, 8'h09, 8'h0A, 16'd8, 1'b0);
        step(); expect_if("h3", 1'b1, 16'h800A, 8'h0A, 8'h0B, 16'd9, 1'b0);
        stall = 1'b1;
        step(); expect_if("h4", 1'b1, 16'h800A, 8'h0A, 8'h0B, 16'd9, 1'b0);
        stall = 1'b0; redirect_valid = 1'b1; redirect_target = 8'h00;
        step(); expect_if("h5", 1'b0, 16'h0000, 8'h00, 8'h00, 16'd9, 1'b0);
        redirect_valid = 1'b0;
        step(); expect_if("h6", 1'b1, 16'h4800, 8'h00, 8'h01, 16'd10, 1'b0);
`endif

        // Reset overrides stall and redirect.
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h33; reset = 1'b1;
        step(); expect_if("rst3", 1'b0, 16'h0000, 8'h00, 8'h00, 16'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
